// File: rtl/display_source_arbiter_if.sv
// Signal bundle between the player/sequencer control (master) and the display source arbiter (slave).
// The master drives tempo, note and pause status; the slave returns the byte and mode for the display path.
interface display_source_arbiter_if;
    logic [7:0] BPM;
    logic [5:0] TONE;
    logic [3:0] DURATION;
    logic       NOTE_STB;
    logic       PAUSED;
    logic [7:0] DISP_VAL;
    logic [1:0] DISP_MODE;
    logic       DISP_BLANK;
    logic       MODE_STB;

    modport master (
        output BPM, TONE, DURATION, NOTE_STB, PAUSED,
        input  DISP_VAL, DISP_MODE, DISP_BLANK, MODE_STB
    );

    modport slave (
        input  BPM, TONE, DURATION, NOTE_STB, PAUSED,
        output DISP_VAL, DISP_MODE, DISP_BLANK, MODE_STB
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Chooses what the 4-digit display shows: live BPM, a timed tone/duration override after each note,
// or a blinking paused indicator. All outputs are registered.
module display_source_arbiter #(
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    display_source_arbiter_if.slave bus
);

    // State encoding equals the DISP_MODE code, so the state register drives DISP_MODE directly.
    typedef enum logic [1:0] {
        S_BPM   = 2'b00,
        S_TONE  = 2'b01,
        S_DUR   = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    localparam logic [26:0] HOLD_LAST  = 27'(HOLD_CYCLES - 1);
    localparam logic [26:0] BLINK_LAST = 27'(BLINK_CYCLES - 1);

    state_t      state, state_d;
    logic [26:0] timer, timer_d;
    logic [5:0]  tone_latch, tone_d;
    logic [3:0]  dur_latch, dur_d;
    logic [7:0]  disp_val, val_d;
    logic        disp_blank, blank_d;
    logic        mode_stb;

    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state;
        timer_d = timer;
        tone_d  = tone_latch;
        dur_d   = dur_latch;
        blank_d = 1'b0;

        if (bus.PAUSED) begin
            state_d = S_PAUSE;
            if (state == S_PAUSE) begin
                if (timer == BLINK_LAST) begin
                    timer_d = '0;
                    blank_d = ~disp_blank;
                end else begin
                    timer_d = timer + 27'd1;
                    blank_d = disp_blank;
                end
            end else begin
                // Any note override in progress is abandoned here; the blink starts unblanked.
                timer_d = '0;
            end
        end else begin
            unique case (state)
                S_BPM: begin
                    if (bus.NOTE_STB) begin
                        state_d = S_TONE;
                        timer_d = '0;
                        tone_d  = bus.TONE;
                        dur_d   = bus.DURATION;
                    end
                end
                S_TONE, S_DUR: begin
                    // A new note outranks a hold expiry in the same cycle and restarts the sequence.
                    if (bus.NOTE_STB) begin
                        state_d = S_TONE;
                        timer_d = '0;
                        tone_d  = bus.TONE;
                        dur_d   = bus.DURATION;
                    end else if (timer == HOLD_LAST) begin
                        state_d = (state == S_TONE) ? S_DUR : S_BPM;
                        timer_d = '0;
                    end else begin
                        timer_d = timer + 27'd1;
                    end
                end
                S_PAUSE: begin
                    state_d = S_BPM;
                    timer_d = '0;
                end
                default: begin
                    state_d = S_BPM;
                    timer_d = '0;
                end
            endcase
        end

        unique case (state_d)
            S_TONE:  val_d = {2'b00, tone_d};
            S_DUR:   val_d = {4'h0, dur_d};
            default: val_d = bus.BPM;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_BPM;
            timer      <= '0;
            tone_latch <= '0;
            dur_latch  <= '0;
            disp_val   <= '0;
            disp_blank <= 1'b0;
            mode_stb   <= 1'b0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            tone_latch <= tone_d;
            dur_latch  <= dur_d;
            disp_val   <= val_d;
            disp_blank <= blank_d;
            mode_stb   <= (state_d != state);
        end
    end

    assign bus.DISP_VAL   = disp_val;
    assign bus.DISP_MODE  = state;
    assign bus.DISP_BLANK = disp_blank;
    assign bus.MODE_STB   = mode_stb;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed and randomized checks of display_source_arbiter against a cycle-count reference model.
module tb_display_source_arbiter;

    localparam int HOLD  = 8;
    localparam int BLINK = 4;

    logic CLK;
    logic RST_N;

    display_source_arbiter_if bus ();

    display_source_arbiter #(
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // Reference model: mode code, cycles spent in the current mode, and the expected outputs.
    int         m_mode;
    int         m_age;
    logic [7:0] m_val;
    logic       m_blank;
    logic       m_stb;
    logic [5:0] m_tone;
    logic [3:0] m_dur;

    task automatic model_reset();
        m_mode  = 0;
        m_age   = 0;
        m_val   = 8'd0;
        m_blank = 1'b0;
        m_stb   = 1'b0;
        m_tone  = 6'd0;
        m_dur   = 4'd0;
    endtask

    task automatic model_edge();
        int prev;
        prev = m_mode;
        if (bus.PAUSED) begin
            if (m_mode != 3) begin
                m_mode = 3;
                m_age  = 0;
            end else begin
                m_age++;
            end
            m_blank = ((m_age / BLINK) % 2) == 1;
            m_val   = bus.BPM;
        end else begin
            m_blank = 1'b0;
            if (m_mode == 3) begin
                m_mode = 0;
                m_age  = 0;
            end else if (bus.NOTE_STB) begin
                m_tone = bus.TONE;
                m_dur  = bus.DURATION;
                m_mode = 1;
                m_age  = 0;
            end else if (m_mode != 0) begin
                m_age++;
                if (m_age == HOLD) begin
                    m_mode = (m_mode == 1) ? 2 : 0;
                    m_age  = 0;
                end
            end
            if (m_mode == 1)      m_val = {2'b00, m_tone};
            else if (m_mode == 2) m_val = {4'h0, m_dur};
            else                  m_val = bus.BPM;
        end
        m_stb = (m_mode != prev);
    endtask

    task automatic check(input string tag);
        logic [1:0] exp_mode;
        exp_mode = m_mode[1:0];
        checks++;
        assert (bus.DISP_MODE === exp_mode) else begin
            errors++;
            $error("FAIL %s DISP_MODE got %0d expected %0d", tag, bus.DISP_MODE, exp_mode);
        end
        checks++;
        assert (bus.DISP_VAL === m_val) else begin
            errors++;
            $error("FAIL %s DISP_VAL got %0d expected %0d", tag, bus.DISP_VAL, m_val);
        end
        checks++;
        assert (bus.DISP_BLANK === m_blank) else begin
            errors++;
            $error("FAIL %s DISP_BLANK got %0b expected %0b", tag, bus.DISP_BLANK, m_blank);
        end
        checks++;
        assert (bus.MODE_STB === m_stb) else begin
            errors++;
            $error("FAIL %s MODE_STB got %0b expected %0b", tag, bus.MODE_STB, m_stb);
        end
    endtask

    // One clock edge: advance the model with the inputs in force, then compare on the falling edge.
    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic note(input logic [5:0] t, input logic [3:0] d, input string tag);
        bus.TONE     = t;
        bus.DURATION = d;
        bus.NOTE_STB = 1'b1;
        step(tag);
        bus.NOTE_STB = 1'b0;
    endtask

    task automatic check_latches(input string tag);
        checks++;
        assert (dut.tone_latch === m_tone) else begin
            errors++;
            $error("FAIL %s tone_latch got %0d expected %0d", tag, dut.tone_latch, m_tone);
        end
        checks++;
        assert (dut.dur_latch === m_dur) else begin
            errors++;
            $error("FAIL %s dur_latch got %0d expected %0d", tag, dut.dur_latch, m_dur);
        end
    endtask

    initial begin
        RST_N        = 1'b0;
        bus.BPM      = 8'd0;
        bus.TONE     = 6'd0;
        bus.DURATION = 4'd0;
        bus.NOTE_STB = 1'b0;
        bus.PAUSED   = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check("reset");

        // Scenario 1: BPM passthrough after reset release.
        bus.BPM = 8'd120;
        RST_N   = 1'b1;
        step("s1_bpm120");
        checks++;
        assert (bus.DISP_VAL === 8'd120) else begin
            errors++;
            $error("FAIL s1_val120 DISP_VAL got %0d expected 120", bus.DISP_VAL);
        end
        bus.BPM = 8'd95;
        step("s1_bpm95");
        checks++;
        assert (bus.DISP_VAL === 8'd95) else begin
            errors++;
            $error("FAIL s1_val95 DISP_VAL got %0d expected 95", bus.DISP_VAL);
        end

        // Scenario 2: full tone/duration/BPM sequence.
        note(6'd37, 4'd5, "s2_strobe");
        checks++;
        assert (bus.DISP_MODE === 2'b01 && bus.DISP_VAL === 8'd37 && bus.MODE_STB === 1'b1) else begin
            errors++;
            $error("FAIL s2_enter mode %0d val %0d stb %0b expected 1 37 1",
                   bus.DISP_MODE, bus.DISP_VAL, bus.MODE_STB);
        end
        steps(20, "s2_seq");

        // Scenario 3a: restart from cycle 5 of the duration phase.
        note(6'd37, 4'd5, "s3_first");
        steps(7, "s3_tone");
        steps(1, "s3_dur0");
        steps(5, "s3_dur");
        note(6'd12, 4'd3, "s3_restart_dur");
        steps(18, "s3_seq");

        // Scenario 3b: restart at cycle 3 of the tone phase (no MODE_STB).
        note(6'd20, 4'd7, "s3b_first");
        steps(3, "s3b_tone");
        note(6'd44, 4'd9, "s3b_restart_tone");
        checks++;
        assert (bus.MODE_STB === 1'b0 && bus.DISP_VAL === 8'd44) else begin
            errors++;
            $error("FAIL s3b_nostb stb %0b val %0d expected 0 44", bus.MODE_STB, bus.DISP_VAL);
        end
        steps(20, "s3b_seq");

        // Scenario 4: pause together with a strobe; strobes during pause are ignored.
        bus.BPM    = 8'd77;
        bus.PAUSED = 1'b1;
        note(6'd50, 4'd6, "s4_pause_strobe");
        for (int i = 0; i < 12; i++) begin
            bus.NOTE_STB = (i % 3 == 1);
            bus.TONE     = 6'(i + 1);
            bus.DURATION = 4'(i);
            step("s4_blink");
        end
        bus.NOTE_STB = 1'b0;
        check_latches("s4_latches");
        bus.PAUSED = 1'b0;
        step("s4_unpause");

        // Scenario 5: pause interrupts a tone, released during the blanked phase.
        note(6'd33, 4'd2, "s5_strobe");
        steps(3, "s5_tone");
        bus.PAUSED = 1'b1;
        steps(6, "s5_pause");
        bus.PAUSED = 1'b0;
        step("s5_unpause");
        checks++;
        assert (bus.DISP_MODE === 2'b00 && bus.DISP_BLANK === 1'b0) else begin
            errors++;
            $error("FAIL s5_resume mode %0d blank %0b expected 0 0", bus.DISP_MODE, bus.DISP_BLANK);
        end
        steps(10, "s5_after");

        // Scenario 6: asynchronous reset in the middle of the duration phase.
        note(6'd40, 4'd8, "s6_strobe");
        steps(11, "s6_dur");
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check("s6_async_reset");
        @(negedge CLK);
        check("s6_in_reset");
        check_latches("s6_latches");
        bus.BPM = 8'd120;
        RST_N   = 1'b1;
        step("s6_bpm120");

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bus.BPM      = 8'($urandom);
            bus.TONE     = 6'($urandom);
            bus.DURATION = 4'($urandom);
            bus.NOTE_STB = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) bus.PAUSED = ~bus.PAUSED;
            step("rand");
        end
        check_latches("rand_latches");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
